// File: rtl/counter_pkg.sv
// counter_pkg: shared encodings for the extended up/down counter
package counter_pkg;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT = 1'b1;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: emits a count tick every presc+1 enabled cycles
module tick_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);
  logic [PRESC_W-1:0] cnt;
  // >= so that lowering presc below the running count still fires and restarts
  assign tick = en && cnt >= presc;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + PRESC_W'(1);
endmodule

// File: rtl/updown_counter_ext.sv
// updown_counter_ext: prescaled up/down counter with limit, wrap/saturate, tc pulse and sticky flags
module updown_counter_ext
  import counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP_W = 4,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               en,
  input  logic               dir,
  input  logic               mode,
  input  logic [STEP_W-1:0]  step,
  input  logic [WIDTH-1:0]   lim,
  input  logic [PRESC_W-1:0] presc,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  input  logic               clr_flags,
  output logic [WIDTH-1:0]   c_out,
  output logic               tc,
  output logic               ovf,
  output logic               unf
);
  localparam int W1 = WIDTH + 1;
  localparam int MW = STEP_W > W1 ? STEP_W : W1;
  logic tick, over, under, above, ev;
  logic [MW-1:0] step_m, lim_m;
  logic [W1-1:0] steff, c_x, lim_x, sum, up_nxt, dn_nxt;
  logic [WIDTH-1:0] c_nxt, ld_val;
  tick_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk(clk), .resetn(resetn), .en(en), .clr(load), .presc(presc), .tick(tick)
  );
  // all arithmetic is one bit wider than the counter so c_out+lim+1 never truncates
  always_comb begin
    step_m = MW'(step);
    lim_m = MW'(lim);
    steff = W1'(step_m > lim_m ? lim_m : step_m);
    c_x = {1'b0, c_out};
    lim_x = {1'b0, lim};
    sum = c_x + steff;
    over = sum > lim_x;
    under = c_x < steff;
    above = c_out > lim;
    up_nxt = over ? (mode == MODE_SAT ? lim_x : sum - lim_x - W1'(1)) : sum;
    dn_nxt = under ? (mode == MODE_SAT ? '0 : c_x + lim_x + W1'(1) - steff) : c_x - steff;
    ev = tick && !above && (dir == DIR_UP ? over : under);
    c_nxt = above ? lim : (dir == DIR_UP ? up_nxt[WIDTH-1:0] : dn_nxt[WIDTH-1:0]);
    ld_val = load_val > lim ? lim : load_val;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      c_out <= '0;
      tc <= 1'b0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (load) begin
      c_out <= ld_val;
      tc <= 1'b0;
    end else begin
      tc <= ev;
      if (tick) c_out <= c_nxt;
      if (en) begin
        ovf <= (ovf & ~clr_flags) | (ev & (dir == DIR_UP));
        unf <= (unf & ~clr_flags) | (ev & (dir == DIR_DOWN));
      end
    end
endmodule

// File: tb/tb_updown_counter_ext.sv
// tb_updown_counter_ext: directed test-plan sequences plus random traffic against an integer model
module tb_updown_counter_ext;
  logic clk = 0, resetn = 0, en = 0, dir = 0, mode = 0, load = 0, clr_flags = 0;
  logic [3:0] step = 0;
  logic [7:0] lim = 0, presc = 0, load_val = 0, c_out;
  logic tc, ovf, unf;
  int total = 0, bad = 0;
  int m_c = 0, m_pc = 0, m_tc = 0, m_ovf = 0, m_unf = 0;

  updown_counter_ext #(.WIDTH(8), .STEP_W(4), .PRESC_W(8)) dut (
    .clk(clk), .resetn(resetn), .en(en), .dir(dir), .mode(mode), .step(step), .lim(lim),
    .presc(presc), .load(load), .load_val(load_val), .clr_flags(clr_flags),
    .c_out(c_out), .tc(tc), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_c = 0; m_pc = 0; m_tc = 0; m_ovf = 0; m_unf = 0;
  endtask

  // count range is 0..lim; wrap is modulo lim+1, saturate clamps to the range
  task automatic model_edge();
    int s, nc, so, su;
    so = 0; su = 0;
    if (load) begin
      m_c = load_val > lim ? int'(lim) : int'(load_val);
      m_pc = 0; m_tc = 0;
    end else if (en) begin
      m_tc = 0;
      if (m_pc >= presc) begin
        m_pc = 0;
        s = step > lim ? int'(lim) : int'(step);
        if (m_c > lim) m_c = lim;
        else if (dir) begin
          nc = m_c + s;
          if (nc > lim) begin so = 1; m_tc = 1; nc = mode ? int'(lim) : nc % (lim + 1); end
          m_c = nc;
        end else begin
          nc = m_c - s;
          if (nc < 0) begin su = 1; m_tc = 1; nc = mode ? 0 : nc + lim + 1; end
          m_c = nc;
        end
      end else m_pc++;
      m_ovf = so | (m_ovf & ~int'(clr_flags));
      m_unf = su | (m_unf & ~int'(clr_flags));
    end else m_tc = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check("c_out", c_out, m_c);
    check("tc", tc, m_tc);
    check("ovf", ovf, m_ovf);
    check("unf", unf, m_unf);
  endtask

  task automatic set_cfg(input logic m, input logic d, input logic [3:0] s, input logic [7:0] l, input logic [7:0] p);
    mode = m; dir = d; step = s; lim = l; presc = p; en = 1;
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1; load_val = v; cyc(); load = 0;
  endtask

  initial begin
    #12;
    check("rst_c", c_out, 0); check("rst_tc", tc, 0); check("rst_ovf", ovf, 0); check("rst_unf", unf, 0);
    @(negedge clk); resetn = 1;

    // legacy behaviour
    set_cfg(0, 1, 1, 8'hFF, 0);
    do_load(8'hFE);
    cyc(); check("leg_ff", c_out, 8'hFF);
    cyc(); check("leg_wrap", c_out, 0); check("leg_tc", tc, 1); check("leg_ovf", ovf, 1);
    dir = 0; cyc(); check("leg_dn", c_out, 8'hFF); check("leg_unf", unf, 1);

    // modulo with step, wrap
    set_cfg(0, 1, 3, 9, 0);
    do_load(0);
    clr_flags = 1; cyc(); clr_flags = 0; check("mod_3", c_out, 3); check("mod_clr", ovf | unf, 0);
    cyc(); check("mod_6", c_out, 6);
    cyc(); check("mod_9", c_out, 9); check("mod_notc", tc, 0);
    cyc(); check("mod_2", c_out, 2); check("mod_tc", tc, 1);
    dir = 0; do_load(1);
    cyc(); check("mod_dn8", c_out, 8); check("mod_unf", unf, 1);

    // saturate
    set_cfg(1, 1, 5, 200, 0);
    do_load(198);
    cyc(); check("sat_200", c_out, 200); check("sat_tc", tc, 1); check("sat_ovf", ovf, 1);
    cyc(); check("sat_again", c_out, 200); check("sat_tc2", tc, 1);
    dir = 0; do_load(3);
    cyc(); check("sat_0", c_out, 0); check("sat_unf", unf, 1);

    // prescaler, enable, load clamp
    set_cfg(0, 1, 1, 255, 3);
    do_load(0);
    repeat (3) cyc();
    check("psc_hold", c_out, 0);
    cyc(); check("psc_tick", c_out, 1);
    repeat (4) cyc();
    check("psc_tick2", c_out, 2);
    en = 0; repeat (2) cyc(); check("en_hold", c_out, 2);
    en = 1; lim = 100; do_load(250); check("ld_clamp", c_out, 100);
    repeat (3) cyc(); check("psc_restart", c_out, 100);
    cyc(); check("psc_wrap", c_out, 0); check("psc_wrap_tc", tc, 1);

    // flag race
    set_cfg(0, 1, 1, 255, 0);
    do_load(255);
    clr_flags = 1; cyc(); check("race_ovf", ovf, 1);
    step = 0; cyc(); clr_flags = 0; check("clr_ovf", ovf, 0); check("clr_unf", unf, 0); check("step0_tc", tc, 0);

    // asynchronous reset mid-count
    step = 1; do_load(8'h37); check("pre_rst", c_out, 8'h37);
    #2 resetn = 0; model_reset(); #1;
    check("arst_c", c_out, 0); check("arst_tc", tc, 0); check("arst_ovf", ovf, 0); check("arst_unf", unf, 0);
    @(negedge clk); resetn = 1;

    // random traffic
    for (int i = 0; i < 600; i++) begin
      en = $urandom_range(0, 9) != 0;
      load = $urandom_range(0, 11) == 0;
      clr_flags = $urandom_range(0, 9) == 0;
      dir = $urandom_range(0, 1);
      mode = $urandom_range(0, 1);
      step = $urandom_range(0, 15);
      presc = $urandom_range(0, 3);
      load_val = $urandom;
      if ($urandom_range(0, 15) == 0) lim = $urandom_range(0, 3) == 0 ? 8'hFF : 8'($urandom_range(0, 40));
      cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
